nes_cpu_bus_master: RTL

Cartridge-facing NES CPU bus cycle generator: the writer/reader side of the mapper bus.
It converts host requests (address, data, R/W) into 2A03-style bus cycles on M2, R/W, /ROMSEL, A and D.
Bank-select writes to $8000-$FFFF then latch in the mapper on the rising edge of /ROMSEL.
It drives mapper RTL in simulation and FPGA cartridge test rigs.

---
 rtl/nes_bus_pkg.sv | 13 +
 rtl/nes_cycle_timer.sv | 43 ++++
 rtl/nes_cpu_bus_master.sv | 120 ++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared types and defaults for the NES CPU bus master and its cycle timer.
package nes_bus_pkg;

  typedef enum logic {
    IDLE_CYC = 1'b0,
    BUS_CYC  = 1'b1
  } cyc_state_e;

  localparam int ROMSEL_ABIT           = 15;
  localparam int DEFAULT_CLK_PER_CYCLE = 12;
  localparam int DEFAULT_M2_LOW_CLKS   = 5;

endpackage

// File: rtl/nes_cycle_timer.sv
// Free-running CPU bus phase counter: registered M2 plus cycle start/end strobes.
module nes_cycle_timer
  import nes_bus_pkg::*;
#(
  parameter int CLK_PER_CYCLE = DEFAULT_CLK_PER_CYCLE,
  parameter int M2_LOW_CLKS   = DEFAULT_M2_LOW_CLKS
) (
  input  logic clk,
  input  logic Nrst,
  output logic m2,
  output logic m2_nxt,
  output logic cycle_start,
  output logic cycle_end
);

  localparam int                PH_W       = $clog2(CLK_PER_CYCLE);
  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(CLK_PER_CYCLE - 1);
  localparam logic [PH_W-1:0]   PH_M2_RISE = PH_W'(M2_LOW_CLKS);

  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_nxt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ph_nxt = (ph == PH_LAST) ? '0 : ph + 1'b1;
    m2_nxt = (ph_nxt >= PH_M2_RISE);
  end

  assign cycle_start = (ph == '0);
  assign cycle_end   = (ph == PH_LAST);

  // M2 is decoded from the next phase and registered so it never glitches.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      ph <= '0;
      m2 <= 1'b0;
    end else begin
      ph <= ph_nxt;
      m2 <= m2_nxt;
    end
  end

endmodule

// File: rtl/nes_cpu_bus_master.sv
// 2A03-style CPU bus cycle generator for driving mapper RTL; define
// NES_BUS_SHADOW_EN to add the bank_shadow mirror of $8000-$FFFF writes.
module nes_cpu_bus_master
  import nes_bus_pkg::*;
#(
  parameter int CLK_PER_CYCLE = DEFAULT_CLK_PER_CYCLE,
  parameter int M2_LOW_CLKS   = DEFAULT_M2_LOW_CLKS
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        req_rw,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        m2,
  output logic        cpu_rw,
  output logic        Ncpu_romsel,
  output logic [14:0] cpu_a,
  output logic [7:0]  cpu_d_out,
  output logic        cpu_d_oe,
  input  logic [7:0]  cpu_d_in
`ifdef NES_BUS_SHADOW_EN
  ,
  output logic [7:0]  bank_shadow
`endif
);

  if (CLK_PER_CYCLE < 4 || M2_LOW_CLKS < 1 || M2_LOW_CLKS > CLK_PER_CYCLE - 1) begin : g_bad_params
    $fatal(1, "nes_cpu_bus_master: illegal CLK_PER_CYCLE/M2_LOW_CLKS");
  end

  logic       m2_nxt;
  logic       cycle_start;
  logic       cycle_end;
  logic       accept;
  logic       a15;
  logic       a15_nxt;
  logic       rw_nxt;
  cyc_state_e state;
  cyc_state_e state_nxt;

  nes_cycle_timer #(
    .CLK_PER_CYCLE (CLK_PER_CYCLE),
    .M2_LOW_CLKS   (M2_LOW_CLKS)
  ) u_timer (
    .clk         (clk),
    .Nrst        (Nrst),
    .m2          (m2),
    .m2_nxt      (m2_nxt),
    .cycle_start (cycle_start),
    .cycle_end   (cycle_end)
  );

  assign req_ready = cycle_end;
  assign accept    = req_valid & cycle_end;

  // Cycle type, A15 and R/W only change on the edge that starts a new bus cycle.
  always_comb begin
    state_nxt = state;
    a15_nxt   = a15;
    rw_nxt    = cpu_rw;
    if (cycle_end) begin
      if (accept) begin
        state_nxt = BUS_CYC;
        a15_nxt   = req_addr[ROMSEL_ABIT];
        rw_nxt    = req_rw;
      end else begin
        state_nxt = IDLE_CYC;
        a15_nxt   = 1'b0;
        rw_nxt    = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state       <= IDLE_CYC;
      a15         <= 1'b0;
      cpu_rw      <= 1'b1;
      Ncpu_romsel <= 1'b1;
      cpu_a       <= '0;
      cpu_d_out   <= '0;
      cpu_d_oe    <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      state  <= state_nxt;
      a15    <= a15_nxt;
      cpu_rw <= rw_nxt;
      // Registered from next-state values so /ROMSEL, M2 and OE switch on one edge.
      Ncpu_romsel <= !(a15_nxt & m2_nxt);
      cpu_d_oe    <= (state_nxt == BUS_CYC) & !rw_nxt & m2_nxt;
      if (accept) begin
        cpu_a <= req_addr[ROMSEL_ABIT-1:0];
        if (!req_rw) cpu_d_out <= req_wdata;
      end
      if (cycle_end && state == BUS_CYC) begin
        resp_valid <= 1'b1;
        resp_rdata <= cpu_rw ? cpu_d_in : 8'h00;
      end else if (cycle_start) begin
        resp_valid <= 1'b0;
      end
    end
  end

`ifdef NES_BUS_SHADOW_EN
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      bank_shadow <= '0;
    end else if (cycle_end && state == BUS_CYC && !cpu_rw && a15) begin
      bank_shadow <= cpu_d_out;
    end
  end
`endif

endmodule
